// File: rtl/axis_to_mips_fifo_loader.sv
// Splits wide AXI4-Stream beats into 32-bit words and streams the first INST_WORDS
// into the instruction FIFO and the following DATA_WORDS into the data FIFO.
module axis_to_mips_fifo_loader #(
    parameter int C_AXIS_WIDTH = 512,
    parameter int INST_WORDS   = 256,
    parameter int DATA_WORDS   = 256
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    i_start,
    input  logic [C_AXIS_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [31:0]             o_inst_fifo_din,
    output logic                    o_inst_fifo_wr_en,
    input  logic                    i_inst_fifo_full,
    output logic [31:0]             o_data_fifo_din,
    output logic                    o_data_fifo_wr_en,
    input  logic                    i_data_fifo_full,
    output logic                    o_busy,
    output logic                    o_load_done,
    output logic                    o_err
);
    localparam int LANES = C_AXIS_WIDTH / 32;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INST = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [C_AXIS_WIDTH-1:0] buf_data_q, buf_data_d;
    logic                    buf_vld_q, buf_vld_d;
    logic                    buf_last_q, buf_last_d;
    logic [LW-1:0]           lane_q, lane_d;
    logic [15:0]             inst_cnt_q, inst_cnt_d;
    logic [15:0]             data_cnt_q, data_cnt_d;
    logic                    err_q, err_d;

    logic [LANES-1:0][31:0]  lanes_w;
    logic                    in_run, tgt_full, pop, last_lane, accept;
    logic                    inst_fin, data_fin;

    assign lanes_w   = buf_data_q;
    assign in_run    = (state_q == S_INST) || (state_q == S_DATA);
    assign tgt_full  = (state_q == S_DATA) ? i_data_fifo_full : i_inst_fifo_full;
    assign pop       = in_run & buf_vld_q & ~tgt_full;
    assign last_lane = (lane_q == LW'(LANES - 1));
    assign inst_fin  = (inst_cnt_q == 16'(INST_WORDS - 1));
    assign data_fin  = (data_cnt_q == 16'(DATA_WORDS - 1));
    assign accept    = s_axis_tvalid & s_axis_tready;

    assign s_axis_tready     = in_run & ~buf_vld_q;
    assign o_inst_fifo_din   = lanes_w[lane_q];
    assign o_data_fifo_din   = lanes_w[lane_q];
    assign o_inst_fifo_wr_en = pop & (state_q == S_INST);
    assign o_data_fifo_wr_en = pop & (state_q == S_DATA);
    assign o_busy            = in_run;
    assign o_load_done       = (state_q == S_DONE);
    assign o_err             = err_q;

    always_comb begin
        state_d    = state_q;
        buf_data_d = buf_data_q;
        buf_vld_d  = buf_vld_q;
        buf_last_d = buf_last_q;
        lane_d     = lane_q;
        inst_cnt_d = inst_cnt_q;
        data_cnt_d = data_cnt_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_INST;
                    inst_cnt_d = '0;
                    data_cnt_d = '0;
                    err_d      = 1'b0;
                    buf_vld_d  = 1'b0;
                end
            end
            S_INST, S_DATA: begin
                if (accept) begin
                    buf_data_d = s_axis_tdata;
                    buf_last_d = s_axis_tlast;
                    lane_d     = '0;
                    buf_vld_d  = 1'b1;
                end
                if (pop) begin
                    lane_d = lane_q + LW'(1);
                    if (last_lane) buf_vld_d = 1'b0;
                    if (state_q == S_INST) begin
                        inst_cnt_d = inst_cnt_q + 16'd1;
                        if (inst_fin) state_d = S_DATA;
                    end else begin
                        data_cnt_d = data_cnt_q + 16'd1;
                        if (data_fin) state_d = S_DONE;
                    end
                    // Stream ended on this word but the data set is not complete yet.
                    if (last_lane && buf_last_q && !((state_q == S_DATA) && data_fin)) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                buf_vld_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= S_IDLE;
            buf_data_q <= '0;
            buf_vld_q  <= 1'b0;
            buf_last_q <= 1'b0;
            lane_q     <= '0;
            inst_cnt_q <= '0;
            data_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_data_q <= buf_data_d;
            buf_vld_q  <= buf_vld_d;
            buf_last_q <= buf_last_d;
            lane_q     <= lane_d;
            inst_cnt_q <= inst_cnt_d;
            data_cnt_q <= data_cnt_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: doc/axis_to_mips_fifo_loader.md
Name: axis_to_mips_fifo_loader

Overview:
- Upstream feeder of the MIPS kernel's FIFO interface stage.
- Accepts the kernel's wide AXI4-Stream input (512-bit beats from the read master), serialises each beat into 32-bit words, and routes them to two FIFOs:
  - the first INST_WORDS words go to the instruction FIFO;
  - the next DATA_WORDS words go to the narrow data-input FIFO.
- Honours FIFO full flags, detects a short stream (early tlast) and signals completion, so the downstream stage sees a complete program followed by a complete data set.

Parameters:
- C_AXIS_WIDTH, 512, input stream width in bits; must be a multiple of 32; LANES = C_AXIS_WIDTH/32.
- INST_WORDS, 256, number of 32-bit instruction words per run (1..65535).
- DATA_WORDS, 256, number of 32-bit data words per run (1..65535).

Ports:
- aclk  in  1  clock
- areset  in  1  reset
- i_start  in  1  one-cycle pulse; begins a load run
- s_axis_tdata  in  C_AXIS_WIDTH  stream data; lane k = bits[32k+31:32k]
- s_axis_tvalid  in  1  stream valid
- s_axis_tlast  in  1  last beat of stream
- s_axis_tready  out  1  stream ready
- o_inst_fifo_din  out  32  instruction word
- o_inst_fifo_wr_en  out  1  instruction FIFO write
- i_inst_fifo_full  in  1  instruction FIFO full
- o_data_fifo_din  out  32  data word
- o_data_fifo_wr_en  out  1  data FIFO write
- i_data_fifo_full  in  1  data FIFO full
- o_busy  out  1  high from start acceptance until done
- o_load_done  out  1  one-cycle pulse at end of run
- o_err  out  1  sticky; early tlast seen; cleared by reset or next accepted i_start

Behaviour:
- Reset: areset, synchronous, active-high; clock aclk. All state, counters and buffer valid cleared; state IDLE; every output 0. Reset mid-run discards the buffered beat without further FIFO writes.
- Holding register: buf_data (C_AXIS_WIDTH), buf_vld, lane pointer lane (0..LANES-1), buf_last.
- s_axis_tready = (state==INST or DATA) & ~buf_vld; combinational.
- Beat acceptance (tvalid & tready): load buf_data, buf_last=tlast, lane=0, buf_vld=1. This gives one bubble cycle per beat, i.e. at most LANES words per LANES+1 cycles.
- Word emission: target = inst FIFO in INST, data FIFO in DATA. Emission is zero latency and combinational:
  - pop = buf_vld & ~target_full;
  - target wr_en = pop;
  - target din = buf_data lane slice;
  - the other FIFO's wr_en = 0; the din of the other FIFO is don't-care and is driven as the same slice.
- On pop: increment the phase counter (16-bit) and lane. When lane==LANES-1, clear buf_vld.
- FSM transitions:
  - IDLE: i_start -> INST. Clear counters; clear o_err; o_busy=1.
  - INST: on the pop where inst_cnt reaches INST_WORDS-1 -> DATA, with the remaining lanes of the same beat continuing into the data FIFO. A word never goes to both FIFOs.
  - DATA: on the pop where data_cnt reaches DATA_WORDS-1 -> DONE.
  - DONE: discard any unused lanes (buf_vld=0). Pulse o_load_done for 1 cycle, o_busy=0, -> IDLE.
- Early tlast: the beat with buf_last drains fully. If the run is then incomplete (buffer emptied in INST/DATA after a last beat), set o_err=1 and go to DONE. o_load_done still pulses.
- Extra stream beats after the counts complete are not accepted (tready=0 in DONE/IDLE).
- i_start outside IDLE is ignored.
- Full held: emission stalls on the same lane indefinitely, with no word lost or duplicated. A full flag on the non-target FIFO has no effect.
- tvalid may drop between beats. Data is sampled only on handshake.

Test Plan:
- INST_WORDS=16, DATA_WORDS=16, LANES=16. Start, two beats of incrementing words 0..31, no full -> inst FIFO receives 0..15 and data FIFO 16..31 in order; o_load_done pulses once 1 cycle after word 31; o_err=0.
- INST_WORDS=20, DATA_WORDS=12, two beats -> lanes 0..15 of beat 0 plus lanes 0..3 of beat 1 go to inst; lanes 4..15 of beat 1 go to data; no word is written to both FIFOs.
- Defaults (256/256), random i_inst_fifo_full / i_data_fifo_full 50% duty, random tvalid gaps -> exactly 256+256 writes, order preserved, no write while the target full flag is high.
- INST_WORDS=16, DATA_WORDS=32, tlast on beat 1 (32 words total) -> 16 inst writes, 16 data writes, then o_err=1 and an o_load_done pulse; next i_start clears o_err.
- areset asserted mid-beat at lane 7 in DATA -> next cycle all outputs 0, tready 0, state IDLE; a new start runs a full clean load.
- i_start pulsed during INST -> ignored; write counts unchanged.
